// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default widths for the memory-port arbiter.
//   state_e : arbiter FSM states
//   len_t   : 5-bit DMA burst length (0..MAX_BURST beats)
package mem_arb_pkg;

  localparam int ADDR_W_DEF       = 16;
  localparam int DATA_W_DEF       = 8;
  localparam int MAX_BURST_DEF    = 16;
  localparam int STARVE_LIMIT_DEF = 8;

  typedef logic [4:0] len_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAR  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the three sides of the arbiter.
//   cpu_* : CPU microcode controller strobes and bus, plus the stall back to it
//   dma_* : DMA requester burst request, write/read data channels and status
//   mem_* : single memory port (MAR load, write strobe, data in, read data)
// Modports:
//   slave  : the arbiter itself
//   master : the surrounding system (controller, DMA requester and memory)
interface mem_arbiter_if #(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W_DEF,
  parameter int DATA_W = mem_arb_pkg::DATA_W_DEF
) ();

  logic              cpu_mar_write_en;
  logic              cpu_mem_write_en;
  logic [ADDR_W-1:0] cpu_bus;
  logic              cpu_stall;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [4:0]        dma_len;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_wvalid;
  logic              dma_wready;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_rvalid;
  logic              dma_busy;
  logic              dma_done;

  logic              mem_mar_write_en;
  logic              mem_write_en;
  logic [ADDR_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_out;

  modport slave (
    input  cpu_mar_write_en, cpu_mem_write_en, cpu_bus,
    output cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_len, dma_wdata, dma_wvalid,
    output dma_wready, dma_rdata, dma_rvalid, dma_busy, dma_done,
    output mem_mar_write_en, mem_write_en, mem_data_in,
    input  mem_out
  );

  modport master (
    output cpu_mar_write_en, cpu_mem_write_en, cpu_bus,
    input  cpu_stall,
    output dma_req, dma_we, dma_addr, dma_len, dma_wdata, dma_wvalid,
    input  dma_wready, dma_rdata, dma_rvalid, dma_busy, dma_done,
    input  mem_mar_write_en, mem_write_en, mem_data_in,
    output mem_out
  );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single memory port between the CPU controller and a
// DMA requester. In IDLE the CPU strobes pass straight through; once DMA is
// granted it owns memory for one burst (MAR load + data beat per byte) and
// any CPU strobe in that window is stalled.
// Ports:
//   clk : system clock
//   rst : asynchronous active-low reset; all outputs forced to 0 while low
//   bus : mem_arbiter_if.slave (CPU, DMA and memory sides)
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | CPU owns memory; grant DMA when it is free or starved
//   MAR     | load memory MAR with the current burst address
//   DATA    | one data beat: write when wvalid, or read for one cycle
//   DONE    | one-cycle burst end pulse, then back to IDLE
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MAX_BURST    = MAX_BURST_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  len_t              beats_q, beats_d;
  logic              we_q, we_d;
  logic [SW-1:0]     starve_q, starve_d;

  logic cpu_strobe;
  logic starve_full;
  logic grant;
  logic beat_done;
  len_t len_in;

  assign cpu_strobe  = bus.cpu_mar_write_en | bus.cpu_mem_write_en;
  assign starve_full = (starve_q == SW'(STARVE_LIMIT));
  // Lengths above the supported burst are clamped rather than wrapped.
  assign len_in      = (bus.dma_len > len_t'(MAX_BURST)) ? len_t'(MAX_BURST) : bus.dma_len;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      beats_q  <= '0;
      we_q     <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      beats_q  <= beats_d;
      we_q     <= we_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    beats_d   = beats_q;
    we_d      = we_q;
    starve_d  = starve_q;
    grant     = 1'b0;
    beat_done = 1'b0;

    bus.cpu_stall        = 1'b0;
    bus.dma_wready       = 1'b0;
    bus.dma_rdata        = '0;
    bus.dma_rvalid       = 1'b0;
    bus.dma_busy         = 1'b0;
    bus.dma_done         = 1'b0;
    bus.mem_mar_write_en = 1'b0;
    bus.mem_write_en     = 1'b0;
    bus.mem_data_in      = '0;

    case (state_q)
      ST_IDLE: begin
        grant = bus.dma_req & (~cpu_strobe | starve_full);
        if (grant) begin
          // A forced grant takes the port away from a CPU strobe this cycle.
          bus.cpu_stall = cpu_strobe;
          we_d          = bus.dma_we;
          addr_d        = bus.dma_addr;
          beats_d       = len_in;
          starve_d      = '0;
          state_d       = (len_in == '0) ? ST_DONE : ST_MAR;
        end else begin
          bus.mem_mar_write_en = bus.cpu_mar_write_en;
          bus.mem_write_en     = bus.cpu_mem_write_en;
          bus.mem_data_in      = bus.cpu_bus;
          if (!bus.dma_req) begin
            starve_d = '0;
          end else if (cpu_strobe && !starve_full) begin
            starve_d = starve_q + 1'b1;
          end
        end
      end

      ST_MAR: begin
        bus.cpu_stall        = cpu_strobe;
        bus.dma_busy         = 1'b1;
        bus.mem_mar_write_en = 1'b1;
        bus.mem_data_in      = addr_q;
        state_d              = ST_DATA;
      end

      ST_DATA: begin
        bus.cpu_stall = cpu_strobe;
        bus.dma_busy  = 1'b1;
        if (we_q) begin
          bus.dma_wready   = 1'b1;
          bus.mem_write_en = bus.dma_wvalid;
          bus.mem_data_in  = {{(ADDR_W - DATA_W){1'b0}}, bus.dma_wdata};
          beat_done        = bus.dma_wvalid;
        end else begin
          bus.dma_rvalid = 1'b1;
          bus.dma_rdata  = bus.mem_out;
          beat_done      = 1'b1;
        end
        if (beat_done) begin
          addr_d  = addr_q + 1'b1;
          beats_d = beats_q - 1'b1;
          state_d = (beats_q == len_t'(1)) ? ST_DONE : ST_MAR;
        end
      end

      ST_DONE: begin
        bus.cpu_stall = cpu_strobe;
        bus.dma_busy  = 1'b1;
        bus.dma_done  = 1'b1;
        state_d       = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // IDLE mirrors CPU strobes combinationally, so reset must gate outputs
    // directly to keep the memory strobes low while rst is held.
    if (!rst) begin
      bus.cpu_stall        = 1'b0;
      bus.dma_wready       = 1'b0;
      bus.dma_rdata        = '0;
      bus.dma_rvalid       = 1'b0;
      bus.dma_busy         = 1'b0;
      bus.dma_done         = 1'b0;
      bus.mem_mar_write_en = 1'b0;
      bus.mem_write_en     = 1'b0;
      bus.mem_data_in      = '0;
    end
  end

endmodule
